sensor_pwr_seq: RTL
===================

Name: sensor_pwr_seq

Overview:
- Sequences sensor bring-up and tear-down: power, input clock, reset/standby release, SERDES reset and training, then stream enable.
- Drives the same sensor/SERDES control bits the register block exposes, with timed, ordered transitions.
- Waits on SERDES lock/done and recovers from link loss.
- Sits between the sensor config register block (start/stop commands) and the sensor/SERDES datapath.

Parameters:
- T_PWR, 1000, cycles held after power enable change (min 1)
- T_CLK, 200, cycles held after inclk enable change (min 1)
- T_RST, 500, cycles held after sysrstn change (min 1)
- T_STB, 500, cycles held after sysstbn change (min 1)
- T_SRST, 16, cycles SERDES/VTC reset held asserted (min 1)
- TRAIN_TO, 1000000, cycles allowed for lock && done after serdes_start (min 1)
- RETRY_MAX, 3, retrain attempts before giving up (1..15)
- TMR_W, 24, timer width; every T_* and TRAIN_TO must be < 2^TMR_W

Ports:
- i_cfg_clk, in, 1: clock
- i_cfg_rst_n, in, 1: asynchronous active-low reset
- i_start, in, 1: single-cycle power-up request
- i_stop, in, 1: single-cycle power-down request
- i_sen_lock, in, 1: SERDES word lock, synchronous to i_cfg_clk
- i_sen_done, in, 1: SERDES training done, synchronous to i_cfg_clk
- o_sen_poweren, out, 1
- o_sen_inclk_en, out, 1
- o_sen_sysrstn, out, 1
- o_sen_sysstbn, out, 1
- o_senvtc_reset, out, 1
- o_serdes_reset, out, 1
- o_serdes_start, out, 1
- o_stream_on, out, 1
- o_state, out, 4: current state encoding
- o_ready, out, 1: high in STREAM
- o_busy, out, 1: state is neither IDLE nor STREAM
- o_err, out, 1: sticky failure flag
- o_retry_cnt, out, 4: retrains used since last start

Behaviour:
- Reset (async assert, sync release):
  - state IDLE.
  - o_senvtc_reset=1, o_serdes_reset=1.
  - All other outputs 0, timer 0, retry count 0.
- Outputs are registered and change on the cycle the state changes.
- Timer:
  - Loaded with T-1 on state entry; decrements every cycle.
  - A timed state exits when timer==0, so it lasts exactly T cycles.
- States (encoding in parentheses):
  - IDLE(0): all off, resets asserted. i_start sets poweren, clears o_err and retry count, goes to PWR.
  - PWR(1): T_PWR, then inclk_en=1 and go to CLK.
  - CLK(2): T_CLK, then sysrstn=1 and go to RST.
  - RST(3): T_RST, then sysstbn=1 and go to STB.
  - STB(4): T_STB, then go to SRST.
  - SRST(5): senvtc_reset=1, serdes_reset=1, serdes_start=0 for T_SRST. Then both resets go to 0, serdes_start=1, go to TRAIN.
  - TRAIN(6):
    - Timer loaded with TRAIN_TO-1.
    - i_sen_lock && i_sen_done sampled high: stream_on=1, go to STREAM.
    - Timeout with retry<RETRY_MAX: retry++, go to SRST.
    - Timeout with retry==RETRY_MAX: o_err=1, go to PDN.
  - STREAM(7):
    - Monitors i_sen_lock only.
    - Lock low for 1 cycle: stream_on=0 the next cycle, serdes_start=0, then retrain per the TRAIN retry rule (retry++ then SRST, or err then PDN).
  - PDN(8..11), four timed sub-states in order:
    - Entry cycle: stream_on=0, serdes_start=0, serdes_reset=1, senvtc_reset=1, sysstbn=0.
    - PDN_STB(8): T_STB, then sysrstn=0.
    - PDN_RST(9): T_RST, then inclk_en=0.
    - PDN_CLK(10): T_CLK, then poweren=0.
    - PDN_PWR(11): T_PWR, then IDLE.
- i_stop:
  - From any state 1..7, go to PDN_STB next cycle; o_err unchanged.
  - Ignored in IDLE and PDN.
- i_start ignored outside IDLE.
- i_start and i_stop in the same cycle: stop wins (in IDLE, both are ignored).
- Lock and done asserting in the same cycle as the timeout expiry: success wins.
- o_err stays set through PDN and IDLE until the next accepted i_start.
- o_retry_cnt saturates at RETRY_MAX and never wraps.

Test Plan (T_PWR=4, T_CLK=3, T_RST=5, T_STB=2, T_SRST=2, TRAIN_TO=10, RETRY_MAX=2):
- Reset then i_start, with lock and done forced high at SRST exit:
  - poweren rises cycle 1, inclk_en at 5, sysrstn at 8, sysstbn at 13.
  - serdes_reset falls and serdes_start rises at 17.
  - stream_on=1 and o_ready=1 at 18.
- Lock/done never asserted:
  - Two retrains; o_retry_cnt=2.
  - Then o_err=1 and the PDN sequence: sysstbn off, then sysrstn 2 cycles later, inclk 5 later, poweren 3 later.
  - IDLE 4 cycles after that.
- In STREAM, drop i_sen_lock for 1 cycle:
  - stream_on=0 the next cycle.
  - SRST entered with retry_cnt=1.
  - Lock restored gives stream_on=1 again.
- i_stop during RST at timer=2: next cycle sysstbn=0, state PDN_STB; full reverse order follows; o_err=0.
- i_start and i_stop in the same cycle:
  - In IDLE: no change.
  - In STREAM: PDN entered.
  - i_start during TRAIN: ignored.
- Assert i_cfg_rst_n low mid-TRAIN:
  - Outputs go to reset values immediately (asynchronously).
  - State IDLE.

Source files
------------

// File: rtl/sensor_pwr_seq.sv
// Sensor power/clock/reset bring-up and tear-down sequencer.
// Walks the sensor through power, input clock, reset and standby release,
// resets and trains the SERDES, then enables streaming. Tear-down reverses
// the order with the same hold times. Link loss or a training timeout
// retrains a bounded number of times before powering down with o_err set.
module sensor_pwr_seq #(
    parameter int unsigned T_PWR     = 1000,
    parameter int unsigned T_CLK     = 200,
    parameter int unsigned T_RST     = 500,
    parameter int unsigned T_STB     = 500,
    parameter int unsigned T_SRST    = 16,
    parameter int unsigned TRAIN_TO  = 1000000,
    parameter int unsigned RETRY_MAX = 3,
    parameter int unsigned TMR_W     = 24
) (
    input  logic       i_cfg_clk,
    input  logic       i_cfg_rst_n,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_sen_lock,
    input  logic       i_sen_done,
    output logic       o_sen_poweren,
    output logic       o_sen_inclk_en,
    output logic       o_sen_sysrstn,
    output logic       o_sen_sysstbn,
    output logic       o_senvtc_reset,
    output logic       o_serdes_reset,
    output logic       o_serdes_start,
    output logic       o_stream_on,
    output logic [3:0] o_state,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_err,
    output logic [3:0] o_retry_cnt
);

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StPwr     = 4'd1,
        StClk     = 4'd2,
        StRst     = 4'd3,
        StStb     = 4'd4,
        StSrst    = 4'd5,
        StTrain   = 4'd6,
        StStream  = 4'd7,
        StPdnStb  = 4'd8,
        StPdnRst  = 4'd9,
        StPdnClk  = 4'd10,
        StPdnPwr  = 4'd11
    } state_e;

    // Timer reload values: a timed state lasts exactly T cycles.
    localparam logic [TMR_W-1:0] LD_PWR   = TMR_W'(T_PWR - 1);
    localparam logic [TMR_W-1:0] LD_CLK   = TMR_W'(T_CLK - 1);
    localparam logic [TMR_W-1:0] LD_RST   = TMR_W'(T_RST - 1);
    localparam logic [TMR_W-1:0] LD_STB   = TMR_W'(T_STB - 1);
    localparam logic [TMR_W-1:0] LD_SRST  = TMR_W'(T_SRST - 1);
    localparam logic [TMR_W-1:0] LD_TRAIN = TMR_W'(TRAIN_TO - 1);
    localparam logic [3:0]       RETRY_LIM = 4'(RETRY_MAX);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [3:0]       retry_q, retry_d;
    logic             err_q, err_d;
    logic             poweren_q, poweren_d;
    logic             inclk_q, inclk_d;
    logic             sysrstn_q, sysrstn_d;
    logic             sysstbn_q, sysstbn_d;
    logic             vtc_rst_q, vtc_rst_d;
    logic             serdes_rst_q, serdes_rst_d;
    logic             serdes_start_q, serdes_start_d;
    logic             stream_q, stream_d;

    logic timer_done;
    logic retrain;
    logic stop_hit;

    assign timer_done = (timer_q == '0);

    // Stop is honoured only while bringing up, training or streaming.
    assign stop_hit = i_stop && (state_q inside {StPwr, StClk, StRst, StStb,
                                                 StSrst, StTrain, StStream});

    // Next-state, timer and registered-output computation.
    always_comb begin
        state_d        = state_q;
        timer_d        = timer_done ? '0 : timer_q - TMR_W'(1);
        retry_d        = retry_q;
        err_d          = err_q;
        poweren_d      = poweren_q;
        inclk_d        = inclk_q;
        sysrstn_d      = sysrstn_q;
        sysstbn_d      = sysstbn_q;
        vtc_rst_d      = vtc_rst_q;
        serdes_rst_d   = serdes_rst_q;
        serdes_start_d = serdes_start_q;
        stream_d       = stream_q;
        retrain        = 1'b0;

        case (state_q)
            StIdle: begin
                // Simultaneous stop cancels the start.
                if (i_start && !i_stop) begin
                    state_d   = StPwr;
                    timer_d   = LD_PWR;
                    poweren_d = 1'b1;
                    err_d     = 1'b0;
                    retry_d   = '0;
                end
            end
            StPwr: begin
                if (timer_done) begin
                    state_d = StClk;
                    timer_d = LD_CLK;
                    inclk_d = 1'b1;
                end
            end
            StClk: begin
                if (timer_done) begin
                    state_d   = StRst;
                    timer_d   = LD_RST;
                    sysrstn_d = 1'b1;
                end
            end
            StRst: begin
                if (timer_done) begin
                    state_d   = StStb;
                    timer_d   = LD_STB;
                    sysstbn_d = 1'b1;
                end
            end
            StStb: begin
                if (timer_done) begin
                    state_d        = StSrst;
                    timer_d        = LD_SRST;
                    vtc_rst_d      = 1'b1;
                    serdes_rst_d   = 1'b1;
                    serdes_start_d = 1'b0;
                end
            end
            StSrst: begin
                if (timer_done) begin
                    state_d        = StTrain;
                    timer_d        = LD_TRAIN;
                    vtc_rst_d      = 1'b0;
                    serdes_rst_d   = 1'b0;
                    serdes_start_d = 1'b1;
                end
            end
            StTrain: begin
                // Success takes priority over a coincident timeout.
                if (i_sen_lock && i_sen_done) begin
                    state_d  = StStream;
                    timer_d  = '0;
                    stream_d = 1'b1;
                end else if (timer_done) begin
                    retrain = 1'b1;
                end
            end
            StStream: begin
                if (!i_sen_lock) begin
                    retrain = 1'b1;
                end
            end
            StPdnStb: begin
                if (timer_done) begin
                    state_d   = StPdnRst;
                    timer_d   = LD_RST;
                    sysrstn_d = 1'b0;
                end
            end
            StPdnRst: begin
                if (timer_done) begin
                    state_d = StPdnClk;
                    timer_d = LD_CLK;
                    inclk_d = 1'b0;
                end
            end
            StPdnClk: begin
                if (timer_done) begin
                    state_d   = StPdnPwr;
                    timer_d   = LD_PWR;
                    poweren_d = 1'b0;
                end
            end
            StPdnPwr: begin
                if (timer_done) begin
                    state_d = StIdle;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase

        // Retrain from SERDES reset while attempts remain, otherwise give up.
        if (retrain) begin
            stream_d       = 1'b0;
            serdes_start_d = 1'b0;
            vtc_rst_d      = 1'b1;
            serdes_rst_d   = 1'b1;
            if (retry_q < RETRY_LIM) begin
                retry_d = retry_q + 4'd1;
                state_d = StSrst;
                timer_d = LD_SRST;
            end else begin
                err_d     = 1'b1;
                state_d   = StPdnStb;
                timer_d   = LD_STB;
                sysstbn_d = 1'b0;
            end
        end

        // Stop overrides everything else and starts the reverse sequence.
        if (stop_hit) begin
            state_d        = StPdnStb;
            timer_d        = LD_STB;
            stream_d       = 1'b0;
            serdes_start_d = 1'b0;
            vtc_rst_d      = 1'b1;
            serdes_rst_d   = 1'b1;
            sysstbn_d      = 1'b0;
            err_d          = err_q;
            retry_d        = retry_q;
        end
    end

    // State, timer and output registers.
    always_ff @(posedge i_cfg_clk or negedge i_cfg_rst_n) begin
        if (!i_cfg_rst_n) begin
            state_q        <= StIdle;
            timer_q        <= '0;
            retry_q        <= '0;
            err_q          <= 1'b0;
            poweren_q      <= 1'b0;
            inclk_q        <= 1'b0;
            sysrstn_q      <= 1'b0;
            sysstbn_q      <= 1'b0;
            vtc_rst_q      <= 1'b1;
            serdes_rst_q   <= 1'b1;
            serdes_start_q <= 1'b0;
            stream_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            retry_q        <= retry_d;
            err_q          <= err_d;
            poweren_q      <= poweren_d;
            inclk_q        <= inclk_d;
            sysrstn_q      <= sysrstn_d;
            sysstbn_q      <= sysstbn_d;
            vtc_rst_q      <= vtc_rst_d;
            serdes_rst_q   <= serdes_rst_d;
            serdes_start_q <= serdes_start_d;
            stream_q       <= stream_d;
        end
    end

    assign o_sen_poweren  = poweren_q;
    assign o_sen_inclk_en = inclk_q;
    assign o_sen_sysrstn  = sysrstn_q;
    assign o_sen_sysstbn  = sysstbn_q;
    assign o_senvtc_reset = vtc_rst_q;
    assign o_serdes_reset = serdes_rst_q;
    assign o_serdes_start = serdes_start_q;
    assign o_stream_on    = stream_q;
    assign o_state        = state_q;
    assign o_ready        = (state_q == StStream);
    assign o_busy         = (state_q != StIdle) && (state_q != StStream);
    assign o_err          = err_q;
    assign o_retry_cnt    = retry_q;

endmodule
